// File: rtl/ahb_matrix_out_arbiter_if.sv
// ahb_matrix_out_arbiter_if: request/handshake bundle between input stages, output port and its arbiter
interface ahb_matrix_out_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_AW = 3
);
  logic [NUM_PORTS-1:0] req_port;
  logic HREADYM;
  logic HSELM;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic HMASTLOCKM;
  logic [PORT_AW-1:0] addr_in_port;
  logic no_port;
  modport master(output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM, input addr_in_port, no_port);
  modport slave(input req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM, output addr_in_port, no_port);
endinterface

// File: rtl/ahb_matrix_out_arbiter.sv
// ahb_matrix_out_arbiter: burst-aware fixed/round-robin output-port arbiter; AHB_ARB_STARVE_GUARD_EN adds starvation promotion
module ahb_matrix_out_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_AW = 3,
  parameter int ARB_MODE = 0,
  parameter int STARVE_LIMIT = 15
) (
  input logic HCLK,
  input logic HRESET,
  ahb_matrix_out_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ = 2'b11;
  logic [PORT_AW-1:0] sel, sel_n, ptr, ptr_n, win;
  logic nop, nop_n, hold, found;
  logic [3:0] cnt, cnt_n;
  logic [NUM_PORTS-1:0] eff, pool, rot;
  if (NUM_PORTS < 2 || NUM_PORTS > 8 || (1 << PORT_AW) < NUM_PORTS || STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad
    $error("ahb_matrix_out_arbiter: illegal parameters");
  end
  // the current owner keeps requesting implicitly while its transfer is live
  always_comb begin
    eff = bus.req_port;
    for (int i = 0; i < NUM_PORTS; i++)
      if (sel == PORT_AW'(i) && !nop && bus.HSELM && bus.HTRANSM != IDLE) eff[i] = 1'b1;
  end
`ifdef AHB_ARB_STARVE_GUARD_EN
  logic [7:0] stv [NUM_PORTS];
  logic [NUM_PORTS-1:0] starved;
  always_comb begin
    starved = '0;
    for (int i = 0; i < NUM_PORTS; i++) starved[i] = ARB_MODE == 0 && eff[i] && stv[i] >= 8'(STARVE_LIMIT);
  end
  assign pool = |starved ? starved : eff;
  always_ff @(posedge HCLK)
    for (int i = 0; i < NUM_PORTS; i++)
      if (HRESET) stv[i] <= '0;
      else if (bus.HREADYM) stv[i] <= eff[i] && !(sel_n == PORT_AW'(i) && !nop_n) ? stv[i] + 8'(stv[i] != 8'hff) : '0;
`else
  assign pool = eff;
`endif
  always_comb begin
    win = '0;
    found = 1'b0;
    rot = NUM_PORTS'({eff, eff} >> ptr);
    if (ARB_MODE == 1) begin
      for (int k = 0; k < NUM_PORTS; k++)
        if (!found && rot[k]) begin
          win = PORT_AW'((int'(ptr) + k) % NUM_PORTS);
          found = 1'b1;
        end
    end else begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) if (pool[i]) win = PORT_AW'(i);
    end
  end
  always_comb begin
    cnt_n = cnt;
    if (!bus.HSELM || bus.HTRANSM == IDLE) cnt_n = '0;
    else if (bus.HTRANSM == NONSEQ) cnt_n = bus.HBURSTM[2:1] == 2'd1 ? 4'd3 : bus.HBURSTM[2:1] == 2'd2 ? 4'd7 : bus.HBURSTM[2:1] == 2'd3 ? 4'd15 : 4'd0;
    else if (bus.HTRANSM == SEQ && cnt != '0) cnt_n = cnt - 4'd1;
  end
  assign hold = cnt != '0 || (bus.HBURSTM == 3'b001 && bus.HTRANSM[0]);
  // a grant out of the idle state counts as a change, so round-robin advances past port 0 after reset
  always_comb begin
    sel_n = sel;
    nop_n = nop;
    ptr_n = ptr;
    if (!bus.HMASTLOCKM && !hold) begin
      if (|eff) begin
        sel_n = win;
        nop_n = 1'b0;
        if (nop || win != sel) ptr_n = int'(win) == NUM_PORTS - 1 ? '0 : win + 1'b1;
      end else nop_n = !bus.HSELM;
    end
  end
  always_ff @(posedge HCLK)
    if (HRESET) begin
      sel <= '0;
      nop <= 1'b1;
      ptr <= '0;
      cnt <= '0;
    end else if (bus.HREADYM) begin
      sel <= sel_n;
      nop <= nop_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
    end
  assign bus.addr_in_port = sel;
  assign bus.no_port = nop;
endmodule

// File: tb/tb_ahb_matrix_out_arbiter.sv
// tb_ahb_matrix_out_arbiter: vector table, corner sequences and random run against a behavioural model, both arbitration modes
module tb_ahb_matrix_out_arbiter;
  localparam int N = 4;
  localparam int AW = 3;
  localparam int LIMIT = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic rdy = 1'b1;
  logic hsel = 1'b0;
  logic lock = 1'b0;
  logic [1:0] htrans = 2'b00;
  logic [2:0] hburst = 3'b000;
  int checks = 0;
  int fails = 0;
  int m_sel[2], m_nop[2], m_ptr[2], m_rem[2];
`ifdef AHB_ARB_STARVE_GUARD_EN
  int m_stv[N];
`endif
  typedef struct {
    logic r;
    logic [3:0] q;
    logic y, s;
    logic [1:0] t;
    logic [2:0] b;
    logic l;
    int fs, fn, rs, rn;
  } vec_t;
  vec_t tbl[14];
  always #5 clk = ~clk;
  ahb_matrix_out_arbiter_if #(.NUM_PORTS(N), .PORT_AW(AW)) if_fp ();
  ahb_matrix_out_arbiter_if #(.NUM_PORTS(N), .PORT_AW(AW)) if_rr ();
  assign if_fp.req_port = req;
  assign if_fp.HREADYM = rdy;
  assign if_fp.HSELM = hsel;
  assign if_fp.HTRANSM = htrans;
  assign if_fp.HBURSTM = hburst;
  assign if_fp.HMASTLOCKM = lock;
  assign if_rr.req_port = req;
  assign if_rr.HREADYM = rdy;
  assign if_rr.HSELM = hsel;
  assign if_rr.HTRANSM = htrans;
  assign if_rr.HBURSTM = hburst;
  assign if_rr.HMASTLOCKM = lock;
  ahb_matrix_out_arbiter #(.NUM_PORTS(N), .PORT_AW(AW), .ARB_MODE(0), .STARVE_LIMIT(LIMIT)) u_fp (
    .HCLK(clk), .HRESET(rst), .bus(if_fp));
  ahb_matrix_out_arbiter #(.NUM_PORTS(N), .PORT_AW(AW), .ARB_MODE(1), .STARVE_LIMIT(LIMIT)) u_rr (
    .HCLK(clk), .HRESET(rst), .bus(if_rr));
  function automatic int burst_len(logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default: return 1;
    endcase
  endfunction
  task automatic model_step();
    int eff, w, cand;
    bit hold;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_sel[m] = 0;
        m_nop[m] = 1;
        m_ptr[m] = 0;
        m_rem[m] = 0;
`ifdef AHB_ARB_STARVE_GUARD_EN
        if (m == 0) for (int i = 0; i < N; i++) m_stv[i] = 0;
`endif
      end else if (rdy) begin
        eff = int'(req);
        if (m_nop[m] == 0 && hsel && htrans != 2'b00) eff = eff | (1 << m_sel[m]);
        hold = m_rem[m] > 0 || (hburst == 3'd1 && (htrans == 2'b01 || htrans == 2'b11));
        cand = eff;
`ifdef AHB_ARB_STARVE_GUARD_EN
        if (m == 0) begin
          int st = 0;
          for (int i = 0; i < N; i++) if (((eff >> i) & 1) == 1 && m_stv[i] >= LIMIT) st = st | (1 << i);
          if (st != 0) cand = st;
        end
`endif
        if (!lock && !hold) begin
          if (eff != 0) begin
            w = -1;
            if (m == 1) begin
              for (int k = 0; k < N; k++) if (w < 0 && ((eff >> ((m_ptr[m] + k) % N)) & 1) == 1) w = (m_ptr[m] + k) % N;
            end else begin
              for (int i = 0; i < N; i++) if (w < 0 && ((cand >> i) & 1) == 1) w = i;
            end
            if (m_nop[m] == 1 || w != m_sel[m]) m_ptr[m] = (w + 1) % N;
            m_sel[m] = w;
            m_nop[m] = 0;
          end else m_nop[m] = hsel ? 0 : 1;
        end
`ifdef AHB_ARB_STARVE_GUARD_EN
        if (m == 0)
          for (int i = 0; i < N; i++)
            if (((eff >> i) & 1) == 1 && !(m_sel[0] == i && m_nop[0] == 0)) m_stv[i] = m_stv[i] < 255 ? m_stv[i] + 1 : 255;
            else m_stv[i] = 0;
`endif
        if (!hsel || htrans == 2'b00) m_rem[m] = 0;
        else if (htrans == 2'b10) m_rem[m] = burst_len(hburst) - 1;
        else if (htrans == 2'b11 && m_rem[m] > 0) m_rem[m] = m_rem[m] - 1;
      end
    end
  endtask
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("fp_sel_model", 8'(if_fp.addr_in_port), 8'(m_sel[0]));
    check("fp_nop_model", 8'(if_fp.no_port), 8'(m_nop[0]));
    check("rr_sel_model", 8'(if_rr.addr_in_port), 8'(m_sel[1]));
    check("rr_nop_model", 8'(if_rr.no_port), 8'(m_nop[1]));
  endtask
  task automatic drive(input logic r, input logic [3:0] q, input logic y, input logic s, input logic [1:0] t, input logic [2:0] b, input logic l);
    rst = r;
    req = q;
    rdy = y;
    hsel = s;
    htrans = t;
    hburst = b;
    lock = l;
  endtask
  task automatic want(input string n, input int fs, input int fn, input int rs, input int rn);
    check({n, "_fp_sel"}, 8'(if_fp.addr_in_port), 8'(fs));
    check({n, "_fp_nop"}, 8'(if_fp.no_port), 8'(fn));
    check({n, "_rr_sel"}, 8'(if_rr.addr_in_port), 8'(rs));
    check({n, "_rr_nop"}, 8'(if_rr.no_port), 8'(rn));
  endtask
  task automatic do_reset();
    drive(1, 4'b0000, 1, 0, 2'b00, 3'b000, 0);
    tick();
    tick();
    want("reset", 0, 1, 0, 1);
  endtask
  initial begin
    tbl[0] = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 0, 1, 0, 1};
    tbl[1] = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 0, 1, 0, 1};
    tbl[2] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 0, 1, 0, 1};
    tbl[3] = '{1'b0, 4'b1010, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1, 0, 1, 0};
    tbl[4] = '{1'b0, 4'b1000, 1'b1, 1'b1, 2'b00, 3'b000, 1'b0, 3, 0, 3, 0};
    tbl[5] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'b10, 3'b000, 1'b0, 3, 0, 3, 0};
    tbl[6] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 3, 1, 3, 1};
    tbl[7] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'b00, 3'b000, 1'b0, 3, 0, 3, 0};
    tbl[8] = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'b00, 3'b000, 1'b0, 3, 0, 3, 0};
    tbl[9] = '{1'b0, 4'b0110, 1'b1, 1'b1, 2'b00, 3'b000, 1'b0, 1, 0, 1, 0};
    tbl[10] = '{1'b0, 4'b0110, 1'b1, 1'b1, 2'b00, 3'b000, 1'b0, 1, 0, 2, 0};
    tbl[11] = '{1'b0, 4'b0001, 1'b1, 1'b1, 2'b00, 3'b000, 1'b1, 1, 0, 2, 0};
    tbl[12] = '{1'b0, 4'b0001, 1'b1, 1'b1, 2'b00, 3'b000, 1'b0, 0, 0, 0, 0};
    tbl[13] = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 0, 1, 0, 1};
    #2;
    for (int v = 0; v < 14; v++) begin
      drive(tbl[v].r, tbl[v].q, tbl[v].y, tbl[v].s, tbl[v].t, tbl[v].b, tbl[v].l);
      tick();
      want($sformatf("vec%0d", v), tbl[v].fs, tbl[v].fn, tbl[v].rs, tbl[v].rn);
    end
    // round-robin rotation with every port requesting and each grant ending in IDLE
    do_reset();
    for (int g = 0; g < 5; g++) begin
      drive(0, 4'b1111, 1, 1, 2'b00, 3'b000, 0);
      tick();
      check($sformatf("rr_rot%0d", g), 8'(if_rr.addr_in_port), 8'(g % 4));
    end
    // INCR4 from port 2 must not be split by port 0, including across a wait state
    do_reset();
    drive(0, 4'b0100, 1, 1, 2'b10, 3'b011, 0);
    tick();
    want("burst_nonseq", 2, 0, 2, 0);
    drive(0, 4'b0101, 1, 1, 2'b11, 3'b011, 0);
    tick();
    want("burst_seq1", 2, 0, 2, 0);
    drive(0, 4'b0101, 0, 1, 2'b11, 3'b011, 0);
    tick();
    want("burst_wait", 2, 0, 2, 0);
    drive(0, 4'b0101, 1, 1, 2'b11, 3'b011, 0);
    tick();
    want("burst_seq2", 2, 0, 2, 0);
    tick();
    want("burst_seq3", 2, 0, 2, 0);
    drive(0, 4'b0001, 1, 1, 2'b00, 3'b000, 0);
    tick();
    want("burst_done", 0, 0, 0, 0);
    // locked transfer from port 3, then frozen wait states
    do_reset();
    drive(0, 4'b1000, 1, 1, 2'b10, 3'b000, 0);
    tick();
    want("lock_grant", 3, 0, 3, 0);
    drive(0, 4'b0001, 1, 1, 2'b10, 3'b000, 1);
    tick();
    want("lock_hold1", 3, 0, 3, 0);
    tick();
    want("lock_hold2", 3, 0, 3, 0);
    drive(0, 4'b0001, 0, 1, 2'b00, 3'b000, 0);
    for (int w = 0; w < 5; w++) begin
      tick();
      want($sformatf("wait%0d", w), 3, 0, 3, 0);
    end
    drive(0, 4'b0001, 1, 1, 2'b00, 3'b000, 0);
    tick();
    want("lock_release", 0, 0, 0, 0);
`ifdef AHB_ARB_STARVE_GUARD_EN
    do_reset();
    drive(0, 4'b0101, 1, 1, 2'b10, 3'b000, 0);
    for (int p = 1; p <= 4; p++) begin
      tick();
      check($sformatf("starve_pt%0d", p), 8'(if_fp.addr_in_port), 8'(p == 4 ? 2 : 0));
    end
`endif
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(63) == 0, 4'($urandom), $urandom_range(3) != 0, $urandom_range(3) != 0,
            2'($urandom), 3'($urandom), $urandom_range(7) == 0);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ahb_matrix_out_arbiter.md
Name: ahb_matrix_out_arbiter

Overview:
- Parametrised output-stage arbiter for the AHB bus matrix. It picks which of NUM_PORTS input stages drives one shared slave (output) port.
- Generalises the fixed two-port arbiter in three ways:
  - any port count;
  - selectable fixed-priority or round-robin mode;
  - burst-aware grant holding, so fixed-length bursts are never split.
- Sits between the input stages and the output stage mux. It drives the mux select and the no-port indication.

Parameters:
- NUM_PORTS, 4, number of input ports requesting this output (2..8).
- PORT_AW, 3, width of addr_in_port; must satisfy 2**PORT_AW >= NUM_PORTS.
- ARB_MODE, 0, 0 = fixed priority (port 0 highest), 1 = round-robin.
- STARVE_LIMIT, 15, arbitration points a requester may lose before promotion (optional feature only; 1..255).

Ports:
- HCLK  input  1  AHB system clock.
- HRESET  input  1  synchronous, active-high reset.
- req_port  input  NUM_PORTS  per-port request; bit i = input port i.
- HREADYM  input  1  transfer done on output port; arbitration point.
- HSELM  input  1  slave select on output port.
- HTRANSM  input  2  output transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HBURSTM  input  3  output burst type.
- HMASTLOCKM  input  1  locked transfer.
- addr_in_port  output  PORT_AW  registered index of selected input port.
- no_port  output  1  registered; 1 = no input port selected.

Interface rule: one clock, HCLK. Reset HRESET is synchronous and active-high.

Behaviour:
Reset and update timing
- On HRESET=1 at a HCLK edge: addr_in_port=0, no_port=1, rr pointer=0, beat counter=0, hold flag=0, starvation counters=0.
- All state updates only on HCLK edges with HREADYM=1. With HREADYM=0 every register holds.
- Latency: a decision made in cycle N (HREADYM=1) is visible on the outputs in cycle N+1.

Effective request
- eff_req[i] = req_port[i] OR (i==addr_in_port AND no_port==0 AND HSELM AND HTRANSM!=IDLE).

Decision priority (highest first)
1. HMASTLOCKM=1: keep current selection and no_port.
2. Burst hold active: keep current selection.
3. Any eff_req set: grant winner.
   - ARB_MODE=0: lowest index wins.
   - ARB_MODE=1: first set bit scanning upward from rr pointer, wrapping at NUM_PORTS-1 to 0.
4. HSELM=1: keep current selection, no_port=0.
5. Otherwise: no_port=1; addr_in_port keeps its value.

Round-robin pointer
- Updated only when the granted index changes: pointer = winner+1, wrapping to 0.
- Unchanged while the same port retains the grant.

Burst hold
- Beat counter width 4 bits.
- On an accepted NONSEQ (HREADYM=1, HSELM=1), load count = beats-1:
  - INCR4/WRAP4: 3.
  - INCR8/WRAP8: 7.
  - INCR16/WRAP16: 15.
  - SINGLE/INCR: 0.
- Each accepted SEQ decrements the counter.
- hold = (count!=0) OR (HBURSTM==INCR AND HTRANSM in {BUSY, SEQ}).
- BUSY never decrements the counter.
- IDLE or HSELM=0 with HREADYM=1 clears the counter (early termination).
- A NONSEQ arriving while count!=0 reloads the counter (new burst).

Other rules
- Simultaneous requests from all ports: resolved purely by mode; no combinational path from req_port to the outputs.
- Indices >= NUM_PORTS are never produced.
- Reset asserted mid-burst: outputs return to their reset values on the next edge, regardless of HREADYM.

Optional Feature:
- Macro: AHB_ARB_STARVE_GUARD_EN.
- When defined, and only with ARB_MODE=0:
  - Each port has an 8-bit counter, incremented at every arbitration point where eff_req[i]=1 but the port is not granted.
  - The counter clears when the port is granted or its request drops.
  - A port whose counter reaches STARVE_LIMIT wins the next arbitration point, still subject to lock and burst hold. If several ports qualify, the lowest index wins.
- When undefined: no counters, pure fixed priority; STARVE_LIMIT is ignored.

Test Plan:
- Reset: HRESET=1 for 2 cycles, then 0 with no requests and HSELM=0 -> addr_in_port=0, no_port=1.
- Fixed priority, ARB_MODE=0: req_port=4'b1010, HREADYM=1 -> next cycle addr_in_port=1, no_port=0. Then req_port=4'b1000, HTRANSM=IDLE -> addr_in_port=3.
- Round-robin, ARB_MODE=1: req_port=4'b1111 held for 4 arbitration points, each grant ending with IDLE -> grants 0,1,2,3, then 0 again.
- Burst hold: port 2 issues INCR4 (NONSEQ + 3 SEQ) while port 0 requests from beat 2 -> addr_in_port stays 2 for all 4 beats and becomes 0 on the cycle after the last SEQ. Insert HREADYM=0 mid-burst -> no change.
- Lock and wait states: HMASTLOCKM=1 on port 3 with req_port=4'b0001 -> addr_in_port stays 3 until HMASTLOCKM=0. HREADYM=0 for 5 cycles -> outputs frozen.
- Starvation guard (macro on, STARVE_LIMIT=3, ARB_MODE=0): port 0 continuously active, port 2 requesting -> port 2 granted at the 4th arbitration point.
